// File: rtl/data_mem_ctrl.sv
// Byte-addressable, big-endian data memory with a valid/ready request handshake,
// a configurable response latency and alignment/range error reporting.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_signed;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_err;
    logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [31:0]       w_rdata;

    assign w_accept = r_ready & i_req_valid;

    // With zero wait cycles RESP is entered on the acceptance edge itself, so the
    // access must use the live request rather than the latched copy.
    assign w_we     = (r_state == StIdle) ? i_req_we     : r_we;
    assign w_size   = (r_state == StIdle) ? i_req_size   : r_size;
    assign w_signed = (r_state == StIdle) ? i_req_signed : r_signed;
    assign w_addr   = (r_state == StIdle) ? i_req_addr   : r_addr;
    assign w_wdata  = (r_state == StIdle) ? i_req_wdata  : r_wdata;

    assign w_enter_resp = i_rst_n &
        ((w_accept && (WAIT_CYCLES == 0)) || ((r_state == StWait) && (r_cnt == 4'd0)));

    assign w_err = (w_size == 2'b11)
                 | ((w_size == 2'b01) & w_addr[0])
                 | ((w_size == 2'b10) & (|w_addr[1:0]))
                 | (|w_addr[31:ADDR_W]);

    assign w_a0 = w_addr[ADDR_W-1:0];
    assign w_a1 = w_a0 + ADDR_W'(1);
    assign w_a2 = w_a0 + ADDR_W'(2);
    assign w_a3 = w_a0 + ADDR_W'(3);

    always_comb begin
        w_rdata = '0;
        unique case (w_size)
            2'b00:   w_rdata = {{24{w_signed & r_mem[w_a0][7]}}, r_mem[w_a0]};
            2'b01:   w_rdata = {{16{w_signed & r_mem[w_a0][7]}}, r_mem[w_a0], r_mem[w_a1]};
            2'b10:   w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
            default: w_rdata = '0;
        endcase
    end

    // The array holds no reset; only committed stores change it.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            unique case (w_size)
                2'b00: r_mem[w_a0] <= w_wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= w_wdata[15:8];
                    r_mem[w_a1] <= w_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_a0] <= w_wdata[31:24];
                    r_mem[w_a1] <= w_wdata[23:16];
                    r_mem[w_a2] <= w_wdata[15:8];
                    r_mem[w_a3] <= w_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_we     <= i_req_we;
                        r_size   <= i_req_size;
                        r_signed <= i_req_signed;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        r_ready  <= 1'b0;
                        r_cnt    <= WaitInit;
                        r_state  <= (WAIT_CYCLES == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
            endcase
            if (w_enter_resp) begin
                r_valid <= 1'b1;
                r_err   <= w_err;
                r_rdata <= (w_we || w_err) ? 32'd0 : w_rdata;
            end
        end
    end

    assign o_req_ready  = r_ready;
    assign o_resp_valid = r_valid;
    assign o_resp_err   = r_err;
    assign o_resp_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset-abort and handshake sweeps,
// and randomized accesses checked against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int N     = 5;
    localparam int DEPTH = 64;
    localparam int unsigned WTAB [N] = '{1, 3, 0, 2, 15};

    logic        clk;
    logic        rst  [N];
    logic        v    [N];
    logic        we   [N];
    logic [1:0]  sz   [N];
    logic        sg   [N];
    logic [31:0] addr [N];
    logic [31:0] wd   [N];
    logic        rdy  [N];
    logic        rv   [N];
    logic        err  [N];
    logic [31:0] rd   [N];

    logic [7:0] ref_mem [N][DEPTH];
    int n_vec = 0;
    int n_bad = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_ctrl #(
            .DEPTH_BYTES(DEPTH),
            .ADDR_W     (6),
            .WAIT_CYCLES(WTAB[g])
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst[g]),
            .i_req_valid (v[g]),
            .o_req_ready (rdy[g]),
            .i_req_we    (we[g]),
            .i_req_size  (sz[g]),
            .i_req_signed(sg[g]),
            .i_req_addr  (addr[g]),
            .i_req_wdata (wd[g]),
            .o_resp_valid(rv[g]),
            .o_resp_rdata(rd[g]),
            .o_resp_err  (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    typedef struct {
        bit        we;
        bit [1:0]  sz;
        bit        sg;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] exp_rd;
        bit        exp_err;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain byte array, big-endian, errors from size/alignment/range rules.
    task automatic ref_access(input int k, input bit w, input bit [1:0] s, input bit sgn,
                              input bit [31:0] a, input bit [31:0] d,
                              output bit [31:0] er, output bit ee);
        int nb;
        bit [31:0] val;
        nb = 1 << s;
        er = 32'd0;
        ee = (s == 2'd3) || (a % nb != 0) || (a >= DEPTH);
        if (ee) return;
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[k][int'(a) + i] = 8'(d >> (8 * (nb - 1 - i)));
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++) val = val * 256 + 32'(ref_mem[k][int'(a) + i]);
            if (sgn && nb < 4 && val >= (32'd1 << (8 * nb - 1))) val = val - (32'd1 << (8 * nb));
            er = val;
        end
    endtask

    // One full transaction; checks handshake and latency, returns the response.
    task automatic do_req(input int k, input bit w, input bit [1:0] s, input bit sgn,
                          input bit [31:0] a, input bit [31:0] d,
                          output bit [31:0] rd_o, output bit err_o);
        int guard;
        int lat;
        bit early;
        @(negedge clk);
        v[k] = 1'b1; we[k] = w; sz[k] = s; sg[k] = sgn; addr[k] = a; wd[k] = d;
        guard = 0;
        while (!rdy[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check($sformatf("accept_timeout[%0d]", k), 32'(guard), 32'd0);
        @(posedge clk);
        #1 v[k] = 1'b0;
        early = 1'b0;
        lat = 0;
        rd_o = '0;
        err_o = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            lat = t;
            if (rdy[k]) early = 1'b1;
            if (rv[k]) begin
                rd_o = rd[k];
                err_o = err[k];
                break;
            end
        end
        check($sformatf("latency[%0d]", k), 32'(lat), 32'(WTAB[k] + 1));
        check($sformatf("ready_low_while_busy[%0d]", k), 32'(early), 32'd0);
        @(negedge clk);
        check($sformatf("resp_pulse_width[%0d]", k), 32'(rv[k]), 32'd0);
    endtask

    task automatic sweep(input int k);
        int per;
        per = int'(WTAB[k]) + 2;
        @(negedge clk);
        v[k] = 1'b1; we[k] = 1'b1; sz[k] = 2'd2; sg[k] = 1'b0; addr[k] = 32'h20;
        wd[k] = $urandom;
        for (int t = 0; t < 4 * per; t++) begin
            if (t > 0) @(negedge clk);
            check($sformatf("sweep_ready[%0d] t=%0d", k, t), 32'(rdy[k]), 32'(t % per == 0));
            check($sformatf("sweep_valid[%0d] t=%0d", k, t), 32'(rv[k]),
                  32'(t % per == int'(WTAB[k]) + 1));
        end
        v[k] = 1'b0;
        repeat (per + 1) @(negedge clk);
    endtask

    initial begin
        bit [31:0] got_rd, exp_rd;
        bit        got_err, exp_err;
        int        seen;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h08, 32'h0,        32'h00000011, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        32'h00000044, 1'b0};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        32'h00003344, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h11223344, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h000000F0, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h11F03344, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        32'hFFFFFFF0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        32'h000000F0, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h0A, 32'hDEADBEEF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h11F03344, 1'b0};
        tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h05, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h08, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h3C, 32'h0,        32'hFFFFCAFE, 1'b0};
        tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h3F, 32'h0,        32'h0,        1'b1};
        tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h80000008, 32'h0,  32'h0,        1'b1};

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0; v[k] = 1'b0; we[k] = 1'b0; sz[k] = 2'd0; sg[k] = 1'b0;
            addr[k] = '0; wd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) rst[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_ready[%0d]", k), 32'(rdy[k]), 32'd1);
            check($sformatf("reset_valid[%0d]", k), 32'(rv[k]), 32'd0);
            check($sformatf("reset_err[%0d]", k), 32'(err[k]), 32'd0);
            check($sformatf("reset_rdata[%0d]", k), rd[k], 32'd0);
        end

        // Directed vectors on the WAIT_CYCLES = 1 instance.
        for (int i = 0; i < 19; i++) begin
            do_req(0, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, got_rd, got_err);
            check($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
        end

        // Reset during the second WAIT cycle abandons the store.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, got_rd, got_err);
        check("abort_prefill_err", 32'(got_err), 32'd0);
        @(negedge clk);
        v[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; sg[1] = 1'b0; addr[1] = 32'h10;
        wd[1] = 32'hAAAAAAAA;
        @(posedge clk);
        #1 v[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        check("abort_ready_in_reset", 32'(rdy[1]), 32'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rv[1]) seen++;
        end
        rst[1] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rv[1]) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got_rd, got_err);
        check("abort_mem_kept", got_rd, 32'h12345678);
        check("abort_reload_err", 32'(got_err), 32'd0);

        // Continuous valid: acceptance spacing and response placement.
        sweep(2);
        sweep(3);
        sweep(4);

        // Randomized accesses against the reference model, every latency.
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < DEPTH; a += 4) begin
                bit [31:0] d;
                d = $urandom;
                ref_access(k, 1'b1, 2'd2, 1'b0, 32'(a), d, exp_rd, exp_err);
                do_req(k, 1'b1, 2'd2, 1'b0, 32'(a), d, got_rd, got_err);
                check($sformatf("init_err[%0d]", k), 32'(got_err), 32'(exp_err));
            end
            for (int i = 0; i < 30; i++) begin
                bit        w, sgn;
                bit [1:0]  s;
                bit [31:0] a, d;
                int        r;
                r = int'($urandom_range(0, 9));
                s = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                r = int'($urandom_range(0, 15));
                if (r == 0)      a = $urandom | 32'h0000_0100;
                else if (r == 1) a = 32'(DEPTH) + $urandom_range(0, 63);
                else             a = $urandom_range(0, DEPTH - 1);
                if (r >= 2 && r < 12 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
                w = 1'($urandom_range(0, 1));
                sgn = 1'($urandom_range(0, 1));
                d = $urandom;
                ref_access(k, w, s, sgn, a, d, exp_rd, exp_err);
                do_req(k, w, s, sgn, a, d, got_rd, got_err);
                check($sformatf("rand[%0d] we=%0d sz=%0d a=%08h rdata", k, w, s, a), got_rd, exp_rd);
                check($sformatf("rand[%0d] we=%0d sz=%0d a=%08h err", k, w, s, a),
                      32'(got_err), 32'(exp_err));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, clocked byte-addressable data memory for the multicycle MIPS CPU. It replaces the combinational word-only RAM with one that adds:
- a valid/ready request handshake;
- byte, halfword and word access sizes, with sign or zero extension on loads;
- a configurable access latency;
- alignment and range error reporting.

It sits between the CPU datapath's MEM stage and the byte array, and stores data big-endian.

Parameters:
DEPTH_BYTES, 64, memory size in bytes; power of two, minimum 4.
ADDR_W, 6, number of byte-address bits used; must equal log2(DEPTH_BYTES).
WAIT_CYCLES, 1, extra cycles between request acceptance and response; range 0..15.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present; held with all req_* stable until accepted.
req_ready  out  1  controller can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle pulse: access complete.
resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
resp_err  out  1  qualified by resp_valid: access rejected.

Behaviour:
- Reset (async assert, sync release) clears control only:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. Acceptance occurs when req_valid & req_ready at a rising edge. On acceptance, latch we/size/signed/addr/wdata.
    - WAIT_CYCLES = 0: go to RESP.
    - Otherwise: go to WAIT with counter = WAIT_CYCLES - 1.
  - WAIT: req_ready = 0. Decrement the counter each cycle; go to RESP when the counter is 0.
  - RESP: req_ready = 0, resp_valid = 1 for exactly one cycle. Next state is IDLE.
  - No back-to-back acceptance: minimum request spacing is WAIT_CYCLES + 2 cycles.
- Latency: the response appears WAIT_CYCLES + 1 cycles after the acceptance edge.
  - Example: WAIT_CYCLES = 1, accepted at edge N, resp_valid high during cycle N+2.
- Error check, evaluated on the latched request:
  - err if size = 11;
  - err if size = 01 and addr[0] != 0;
  - err if size = 10 and addr[1:0] != 0;
  - err if addr >= DEPTH_BYTES, i.e. any bit of addr[31:ADDR_W] set.
  - On err: no memory write, resp_rdata = 0, resp_err = 1.
- Big-endian byte order: byte at addr holds the most significant byte of the addressed word.
  - Word store: mem[a] = wdata[31:24], mem[a+1] = [23:16], mem[a+2] = [15:8], mem[a+3] = [7:0].
  - Half store: mem[a] = wdata[15:8], mem[a+1] = wdata[7:0].
  - Byte store: mem[a] = wdata[7:0].
- Write commit: a store writes the array on the edge that enters RESP, and only if there is no error.
  - Bytes outside the accessed size are untouched.
  - Stores return resp_rdata = 0, resp_err = 0.
- Load: the array is read on the edge that enters RESP; resp_rdata is registered.
  - Byte loads extend from bit 7, half loads from bit 15, per req_signed. Word loads ignore req_signed.
- Reset asserted mid-operation (WAIT or RESP-entry pending):
  - the transaction is abandoned, no write is committed, no response is issued;
  - the array retains all previously committed data.
- Unaccepted requests (valid while not ready) have no effect. The requester must hold them.
- Top address: a word at DEPTH_BYTES-4 is legal. A half at DEPTH_BYTES-1 is misaligned, so err.

Test Plan:
1. Reset with WAIT_CYCLES = 1: deassert rst_n -> req_ready = 1, resp_valid = 0; word store 0x11223344 @0x08 accepted edge N -> resp_valid in cycle N+2, err = 0, req_ready low during N+1..N+2.
2. Endianness: after test 1, byte load unsigned @0x08 -> 0x00000011; byte @0x0B -> 0x00000044; half @0x0A -> 0x00003344; word @0x08 -> 0x11223344.
3. Partial store and extension: store byte 0xF0 @0x09, then word load @0x08 -> 0x11F03344; signed byte load @0x09 -> 0xFFFFFFF0; unsigned -> 0x000000F0.
4. Errors: word store 0xDEADBEEF @0x0A -> resp_err = 1, rdata = 0, word @0x08 still 0x11F03344; half load @0x05 -> err; size = 11 -> err; word load @0x40 (DEPTH 64) -> err; word @0x3C -> ok.
5. Reset mid-op: WAIT_CYCLES = 3, store 0xAAAAAAAA @0x10 (prefilled 0x12345678), pull rst_n low in the second WAIT cycle -> no resp_valid; after release, word load @0x10 -> 0x12345678.
6. Handshake/latency sweep: WAIT_CYCLES in {0, 2, 15}, req_valid held high continuously -> exactly one acceptance per WAIT_CYCLES + 2 cycles, resp_valid pulse one cycle wide at acceptance + WAIT_CYCLES + 1.
